// File: rtl/single_dot_grad_v_v_if.sv
// Operand/result bundle for single_dot_grad_v_v: start, scalar gradient, operand vectors, status and results.
interface single_dot_grad_v_v_if #(
   parameter int unsigned WIDTH = 10
);
   logic                   start;
   logic [31:0]            g;
   logic [WIDTH-1:0][31:0] vector_a;
   logic [WIDTH-1:0][31:0] vector_b;
   logic                   busy;
   logic                   done;
   logic [WIDTH-1:0][31:0] grad_a;
   logic [WIDTH-1:0][31:0] grad_b;

   modport master (output start, g, vector_a, vector_b,
                   input  busy, done, grad_a, grad_b);
   modport slave  (input  start, g, vector_a, vector_b,
                   output busy, done, grad_a, grad_b);
endinterface

// File: rtl/single_dot_grad_v_v.sv
// Dot-product backward pass: grad_a[i] = g*vector_b[i], grad_b[i] = g*vector_a[i], one pair per cycle.
// grad_b datapath is present only when SINGLE_DOT_GRAD_B_EN is defined; otherwise grad_b is tied to zero.

// Pipelined float32 multiply, round-to-nearest-even, subnormal inputs/results flushed to signed zero.
module single_multiply #(
   parameter int unsigned LATENCY = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   output logic [31:0] result
);
   logic              sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, guard, sticky;
   logic [47:0]       prod;
   logic [22:0]       mant;
   logic [23:0]       mant_r;
   logic signed [9:0] exp_n, exp_r;
   logic [31:0]       prod_c;
   logic [LATENCY-1:0]       vld_q;
   logic [LATENCY-1:0][31:0] dat_q;

   always_comb begin
      sgn    = a[31] ^ b[31];
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_zero = (a[30:23] == 8'h00);
      b_zero = (b[30:23] == 8'h00);
      prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      exp_n  = 10'(a[30:23]) + 10'(b[30:23]) - 10'sd127;
      if (prod[47]) begin
         mant   = prod[46:24];
         guard  = prod[23];
         sticky = |prod[22:0];
         exp_n  = exp_n + 10'sd1;
      end else begin
         mant   = prod[45:23];
         guard  = prod[22];
         sticky = |prod[21:0];
      end
      mant_r = {1'b0, mant} + 24'(guard & (sticky | mant[0]));
      exp_r  = mant_r[23] ? exp_n + 10'sd1 : exp_n;
      // Special operands first, then exponent range of the normal product
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         prod_c = 32'h7FC0_0000;
      else if (a_inf || b_inf)
         prod_c = {sgn, 8'hFF, 23'd0};
      else if (a_zero || b_zero)
         prod_c = {sgn, 31'd0};
      else if (exp_r >= 10'sd255)
         prod_c = {sgn, 8'hFF, 23'd0};
      else if (exp_r <= 10'sd0)
         prod_c = {sgn, 31'd0};
      else
         prod_c = {sgn, exp_r[7:0], mant_r[22:0]};
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         vld_q <= '0;
         dat_q <= '0;
      end else begin
         vld_q[0] <= in_valid;
         dat_q[0] <= prod_c;
         for (int k = 1; k < int'(LATENCY); k++) begin
            vld_q[k] <= vld_q[k-1];
            dat_q[k] <= dat_q[k-1];
         end
      end
   end

   assign out_valid = vld_q[LATENCY-1];
   assign result    = dat_q[LATENCY-1];
endmodule

module single_dot_grad_v_v #(
   parameter int unsigned WIDTH       = 10,
   parameter int unsigned MUL_LATENCY = 4
) (
   input logic                 clk,
   input logic                 rstn,
   single_dot_grad_v_v_if.slave bus
);
   localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       issue_q, issue_d, wr_q, wr_d;
   logic [31:0]            g_q, g_d;
   logic                   busy_q, busy_d, done_q, done_d;
   logic                   mul_valid_c;
   logic                   a_valid;
   logic [31:0]            a_res;
   logic [WIDTH-1:0][31:0] grad_a_q;

   // Next-state: the write index advances only on multiplier A's out_valid
   always_comb begin
      state_d     = state_q;
      issue_d     = issue_q;
      wr_d        = wr_q;
      g_d         = g_q;
      busy_d      = busy_q;
      done_d      = done_q;
      mul_valid_c = 1'b0;
      if (a_valid) wr_d = wr_q + IDX_W'(1);
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = ISSUE;
               g_d     = bus.g;
               issue_d = '0;
               wr_d    = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         end
         ISSUE: begin
            mul_valid_c = 1'b1;
            issue_d     = issue_q + IDX_W'(1);
            if (issue_q == IDX_W'(WIDTH - 1)) state_d = DRAIN;
         end
         DRAIN: begin
            if (a_valid && (wr_q == IDX_W'(WIDTH - 1))) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         issue_q <= '0;
         wr_q    <= '0;
         g_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         issue_q <= issue_d;
         wr_q    <= wr_d;
         g_q     <= g_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   single_multiply #(.LATENCY(MUL_LATENCY)) u_mul_a (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (mul_valid_c),
      .a        (g_q),
      .b        (bus.vector_b[issue_q]),
      .out_valid(a_valid),
      .result   (a_res)
   );

   always_ff @(posedge clk) begin
      if (!rstn)        grad_a_q       <= '0;
      else if (a_valid) grad_a_q[wr_q] <= a_res;
   end

`ifdef SINGLE_DOT_GRAD_B_EN
   logic                   b_valid;
   logic [31:0]            b_res;
   logic [WIDTH-1:0][31:0] grad_b_q;

   single_multiply #(.LATENCY(MUL_LATENCY)) u_mul_b (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (mul_valid_c),
      .a        (g_q),
      .b        (bus.vector_a[issue_q]),
      .out_valid(b_valid),
      .result   (b_res)
   );

   always_ff @(posedge clk) begin
      if (!rstn)        grad_b_q       <= '0;
      else if (b_valid) grad_b_q[wr_q] <= b_res;
   end

   assign bus.grad_b = grad_b_q;
`else
   assign bus.grad_b = '0;
`endif

   assign bus.grad_a = grad_a_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
endmodule
